// File: rtl/wb_shared_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the data and
// instruction-fetch ports of NUM_CPU j1 CPU slaves; one access in flight at a time.
module wb_shared_ram_arbiter #(
    parameter int unsigned NUM_CPU = 4,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CPU-1:0]      cpu_cyc_i,
    input  logic [NUM_CPU-1:0]      cpu_we_i,
    input  logic [32*NUM_CPU-1:0]   cpu_adr_i,
    input  logic [32*NUM_CPU-1:0]   cpu_dat_i,
    output logic [NUM_CPU-1:0]      cpu_ack_o,
    output logic [31:0]             cpu_dat_o,
    input  logic [NUM_CPU-1:0]      inst_cyc_i,
    input  logic [14*NUM_CPU-1:0]   inst_pc_i,
    output logic [NUM_CPU-1:0]      inst_ack_o,
    output logic [31:0]             inst_dat_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_adr_o,
    output logic [31:0]             mem_dat_o,
    input  logic [31:0]             mem_dat_i,
    output logic                    busy_o
);
    localparam int unsigned NUM_REQ = 2 * NUM_CPU;
    localparam int unsigned IDX_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    gnt;
    logic [CNT_W-1:0]    lat_cnt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_adr;
    logic [31:0]         lat_dat;

    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  req_we;
    logic [ADDR_W-1:0]   req_adr [NUM_REQ];
    logic [31:0]         req_dat [NUM_REQ];

    logic                found;
    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    nxt_ptr;
    logic                issue;
    logic                ack_hit;

    // Requester r = 2k is CPU k's data port, r = 2k+1 its fetch port (always a read)
    for (genvar k = 0; k < NUM_CPU; k++) begin : g_req
        assign req[2*k]        = cpu_cyc_i[k];
        assign req_we[2*k]     = cpu_we_i[k];
        assign req_adr[2*k]    = ADDR_W'(cpu_adr_i[32*k +: 32]);
        assign req_dat[2*k]    = cpu_dat_i[32*k +: 32];
        assign req[2*k+1]      = inst_cyc_i[k];
        assign req_we[2*k+1]   = 1'b0;
        assign req_adr[2*k+1]  = ADDR_W'(inst_pc_i[14*k +: 14]);
        assign req_dat[2*k+1]  = 32'h0;

        assign cpu_ack_o[k]    = ack_hit && (gnt == IDX_W'(2*k));
        assign inst_ack_o[k]   = ack_hit && (gnt == IDX_W'(2*k+1));
    end

    // First asserted request searching circularly from ptr
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        nxt_ptr = win + IDX_W'(1);
        if (win == IDX_W'(NUM_REQ - 1)) begin
            nxt_ptr = '0;
        end
    end

    // The RAM sees the winner in the same cycle it is chosen; reset blocks any issue
    assign issue     = !rst && (state == S_IDLE) && found;
    assign mem_en_o  = issue;
    assign mem_we_o  = issue && req_we[win];
    assign mem_adr_o = issue ? req_adr[win] : lat_adr;
    assign mem_dat_o = issue ? req_dat[win] : lat_dat;

    // A requester that withdrew during the access gets no ack
    assign ack_hit   = (state == S_ACK) && req[gnt];
    assign busy_o    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            gnt        <= '0;
            lat_cnt    <= '0;
            lat_we     <= 1'b0;
            lat_adr    <= '0;
            lat_dat    <= '0;
            cpu_dat_o  <= '0;
            inst_dat_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state   <= S_WAIT;
                        gnt     <= win;
                        ptr     <= nxt_ptr;
                        lat_we  <= req_we[win];
                        lat_adr <= req_adr[win];
                        lat_dat <= req_dat[win];
                        lat_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == CNT_W'(RD_LAT - 1)) begin
                        state <= S_ACK;
                        // Write read-back is meaningless, so keep the last read value
                        if (!lat_we) begin
                            if (gnt[0]) begin
                                inst_dat_o <= mem_dat_i;
                            end else begin
                                cpu_dat_o  <= mem_dat_i;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_shared_ram_arbiter.sv
// Bench for wb_shared_ram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model with its own RAM image.
module tb_wb_shared_ram_arbiter;
    localparam int unsigned N0 = 4;
    localparam int unsigned AW = 12;
    localparam int unsigned L0 = 1;
    localparam int unsigned N1 = 2;
    localparam int unsigned L1 = 3;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT 0: 4 CPUs, read latency 1
    logic [N0-1:0]    cpu_cyc, cpu_we, cpu_ack, inst_cyc, inst_ack;
    logic [32*N0-1:0] cpu_adr, cpu_dat;
    logic [14*N0-1:0] inst_pc;
    logic [31:0]      cpu_dat_o0, inst_dat_o0, mem_wdat0, mem_rdat0;
    logic             mem_en0, mem_we0, busy0;
    logic [AW-1:0]    mem_adr0;

    // DUT 1: 2 CPUs, read latency 3
    logic [N1-1:0]    cpu_cyc1, cpu_we1, cpu_ack1, inst_cyc1, inst_ack1;
    logic [32*N1-1:0] cpu_adr1, cpu_dat1;
    logic [14*N1-1:0] inst_pc1;
    logic [31:0]      cpu_dat_o1, inst_dat_o1, mem_wdat1, mem_rdat1;
    logic             mem_en1, mem_we1, busy1;
    logic [AW-1:0]    mem_adr1;

    wb_shared_ram_arbiter #(.NUM_CPU(N0), .ADDR_W(AW), .RD_LAT(L0)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_cyc_i(cpu_cyc), .cpu_we_i(cpu_we), .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat),
        .cpu_ack_o(cpu_ack), .cpu_dat_o(cpu_dat_o0),
        .inst_cyc_i(inst_cyc), .inst_pc_i(inst_pc), .inst_ack_o(inst_ack), .inst_dat_o(inst_dat_o0),
        .mem_en_o(mem_en0), .mem_we_o(mem_we0), .mem_adr_o(mem_adr0), .mem_dat_o(mem_wdat0),
        .mem_dat_i(mem_rdat0), .busy_o(busy0)
    );

    wb_shared_ram_arbiter #(.NUM_CPU(N1), .ADDR_W(AW), .RD_LAT(L1)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_cyc_i(cpu_cyc1), .cpu_we_i(cpu_we1), .cpu_adr_i(cpu_adr1), .cpu_dat_i(cpu_dat1),
        .cpu_ack_o(cpu_ack1), .cpu_dat_o(cpu_dat_o1),
        .inst_cyc_i(inst_cyc1), .inst_pc_i(inst_pc1), .inst_ack_o(inst_ack1), .inst_dat_o(inst_dat_o1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_adr_o(mem_adr1), .mem_dat_o(mem_wdat1),
        .mem_dat_i(mem_rdat1), .busy_o(busy1)
    );

    // RAM macros: data appears RD_LAT cycles after the enable, poison otherwise
    logic [31:0] ram0 [64];
    logic [31:0] ram1 [64];
    logic [31:0] rd1_p0, rd1_p1;
    logic        ld_en;
    logic [5:0]  ld_adr;
    logic [31:0] ld_dat;

    always @(posedge clk) begin
        if (ld_en) begin
            ram0[ld_adr] <= ld_dat;
            ram1[ld_adr] <= ld_dat;
        end else begin
            if (mem_en0 && mem_we0) ram0[mem_adr0[5:0]] <= mem_wdat0;
            if (mem_en1 && mem_we1) ram1[mem_adr1[5:0]] <= mem_wdat1;
        end
        mem_rdat0 <= mem_en0 ? ram0[mem_adr0[5:0]] : POISON;
        rd1_p0    <= mem_en1 ? ram1[mem_adr1[5:0]] : POISON;
        rd1_p1    <= rd1_p0;
        mem_rdat1 <= rd1_p1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Acks of DUT 0 indexed by requester number
    function automatic logic [7:0] ackv0();
        return {inst_ack[3], cpu_ack[3], inst_ack[2], cpu_ack[2],
                inst_ack[1], cpu_ack[1], inst_ack[0], cpu_ack[0]};
    endfunction

    // Reference model state
    logic [31:0] m_ram [64];
    logic        p_act [8];
    logic        p_we  [8];
    logic [31:0] p_adr [8];
    logic [31:0] p_dat [8];
    logic [31:0] m_rd;
    logic [31:0] tmp;
    logic [11:0] exp_adr;
    int          m_ptr, m_k, m_gnt, w, drop_r, prev, rr;

    task automatic apply_rand();
        cpu_cyc = '0; cpu_we = '0; cpu_adr = '0; cpu_dat = '0; inst_cyc = '0; inst_pc = '0;
        for (int k = 0; k < 4; k++) begin
            cpu_cyc  |= 4'(p_act[2*k]) << k;
            cpu_we   |= 4'(p_we[2*k]) << k;
            cpu_adr  |= 128'(p_adr[2*k]) << (32*k);
            cpu_dat  |= 128'(p_dat[2*k]) << (32*k);
            inst_cyc |= 4'(p_act[2*k+1]) << k;
            inst_pc  |= 56'(14'(p_adr[2*k+1])) << (14*k);
        end
    endtask

    initial begin
        rst = 1'b1;
        ld_en = 1'b0; ld_adr = '0; ld_dat = '0;
        cpu_cyc = 4'hF; inst_cyc = 4'hF; cpu_we = 4'hF;
        cpu_adr = '0; cpu_dat = '1; inst_pc = '0;
        cpu_cyc1 = '0; cpu_we1 = '0; cpu_adr1 = '0; cpu_dat1 = '0; inst_cyc1 = '0; inst_pc1 = '0;

        // Preload both RAMs while reset holds the arbiters off the bus
        for (int i = 0; i < 64; i++) begin
            ld_en  = 1'b1;
            ld_adr = 6'(i);
            ld_dat = (i == 16) ? 32'hDEADBEEF : $urandom;
            m_ram[i] = ld_dat;
            step();
        end
        ld_en = 1'b0;
        #2;
        chk("rst_busy", busy0, 0);
        chk("rst_mem", {mem_en0, mem_we0, mem_adr0, mem_wdat0}, 0);
        chk("rst_acks", ackv0(), 0);
        chk("rst_dat", {cpu_dat_o0, inst_dat_o0}, 0);
        chk("rst_dut1", {busy1, mem_en1, inst_ack1, cpu_ack1}, 0);
        cpu_cyc = '0; inst_cyc = '0; cpu_we = '0; cpu_dat = '0;
        rst = 1'b0;
        step();

        // Single data read by CPU1 (upper address bits must be ignored)
        step();
        cpu_cyc = 4'b0010; cpu_adr[63:32] = 32'hFFFF_F010;
        #2;
        chk("t1_issue", {mem_en0, mem_we0, mem_adr0}, {1'b1, 1'b0, 12'h010});
        chk("t1_busy0", busy0, 0);
        step(); #2;
        chk("t1_wait", {busy0, mem_en0, ackv0()}, {1'b1, 1'b0, 8'h00});
        step(); #2;
        chk("t1_ack", {inst_ack, cpu_ack}, {4'b0000, 4'b0010});
        chk("t1_dat", cpu_dat_o0, 32'hDEADBEEF);
        step();
        cpu_cyc = '0;
        #2;
        chk("t1_idle", {busy0, ackv0()}, 0);

        // CPU0 writes, then fetches the same word
        step();
        cpu_cyc = 4'b0001; cpu_we = 4'b0001;
        cpu_adr[31:0] = 32'h0000_0020; cpu_dat[31:0] = 32'h12345678;
        #2;
        chk("t2_wr_issue", {mem_en0, mem_we0, mem_adr0}, {1'b1, 1'b1, 12'h020});
        chk("t2_wr_dat", mem_wdat0, 32'h12345678);
        m_ram[32] = 32'h12345678;
        step(); step(); #2;
        chk("t2_wr_ack", ackv0(), 8'b0000_0001);
        step();
        cpu_cyc = '0; cpu_we = '0;
        inst_cyc = 4'b0001; inst_pc[13:0] = 14'h0020;
        #2;
        chk("t2_fetch_issue", {mem_en0, mem_we0, mem_adr0}, {1'b1, 1'b0, 12'h020});
        step(); step(); #2;
        chk("t2_fetch_ack", {inst_ack, cpu_ack}, {4'b0001, 4'b0000});
        chk("t2_fetch_dat", inst_dat_o0, 32'h12345678);
        step();
        inst_cyc = '0;

        // CPU2 write withdrawn during WAIT: committed, never acked
        step();
        cpu_cyc = 4'b0100; cpu_we = 4'b0100;
        cpu_adr[95:64] = 32'h0000_0005; cpu_dat[95:64] = 32'hCAFEF00D;
        #2;
        chk("t4_issue", {mem_en0, mem_we0, mem_adr0, mem_wdat0}, {1'b1, 1'b1, 12'h005, 32'hCAFEF00D});
        m_ram[5] = 32'hCAFEF00D;
        step();
        cpu_cyc = '0; cpu_we = '0;
        #2;
        chk("t4_wait", {busy0, ackv0()}, {1'b1, 8'h00});
        step(); #2;
        chk("t4_noack", {busy0, ackv0()}, {1'b1, 8'h00});
        step(); #2;
        chk("t4_idle", {busy0, mem_en0}, 0);
        step();
        cpu_cyc = 4'b1000; cpu_adr[127:96] = 32'h0000_0005;
        #2;
        chk("t4_rd_issue", {mem_en0, mem_adr0}, {1'b1, 12'h005});
        step(); step(); #2;
        chk("t4_rd_ack", cpu_ack, 4'b1000);
        chk("t4_rd_dat", cpu_dat_o0, 32'hCAFEF00D);
        step();
        cpu_cyc = '0;

        // Asynchronous reset while CPU1's fetch waits on the RAM
        step();
        inst_cyc = 4'b0010; inst_pc[27:14] = 14'h0007;
        #2;
        chk("t5_issue", {mem_en0, mem_adr0}, {1'b1, 12'h007});
        step(); #2;
        chk("t5_wait", busy0, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_ctl", {busy0, mem_en0, mem_we0, ackv0()}, 0);
        chk("t5_rst_bus", {mem_adr0, mem_wdat0}, 0);
        chk("t5_rst_dat", {cpu_dat_o0, inst_dat_o0}, 0);
        inst_cyc = '0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); #2;
            chk("t5_no_ack", {busy0, ackv0()}, 0);
        end

        // All eight requesters held: strict rotation from requester 0
        step();
        cpu_cyc = 4'hF; inst_cyc = 4'hF; cpu_we = '0;
        cpu_adr = {32'h33, 32'h32, 32'h31, 32'h30};
        inst_pc = {14'h3B, 14'h3A, 14'h39, 14'h38};
        for (int g = 0; g < 9; g++) begin
            rr = g % 8;
            exp_adr = (rr % 2 == 0) ? 12'(12'h30 + rr / 2) : 12'(12'h38 + rr / 2);
            #2;
            chk("rr_issue", {mem_en0, mem_we0, mem_adr0}, {1'b1, 1'b0, exp_adr});
            step(); #2;
            chk("rr_wait", ackv0(), 0);
            step(); #2;
            chk("rr_ack", ackv0(), 8'(1) << rr);
            chk("rr_dat", (rr % 2 == 1) ? inst_dat_o0 : cpu_dat_o0, m_ram[exp_adr[5:0]]);
            step();
        end
        cpu_cyc = '0; inst_cyc = '0;
        #2;
        chk("rr_done", {busy0, mem_en0}, 0);

        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Read latency 3: fetch at cycle 0 is acked at cycle 4
        step();
        inst_cyc1 = 2'b01; inst_pc1[13:0] = 14'h0011;
        #2;
        chk("l3_issue", {mem_en1, mem_we1, mem_adr1}, {1'b1, 1'b0, 12'h011});
        for (int i = 1; i <= 3; i++) begin
            step(); #2;
            chk("l3_wait", {busy1, mem_en1, inst_ack1, cpu_ack1}, {1'b1, 1'b0, 4'b0000});
        end
        step(); #2;
        chk("l3_ack", {inst_ack1, cpu_ack1}, {2'b01, 2'b00});
        chk("l3_dat", inst_dat_o1, m_ram[17]);
        step();
        inst_cyc1 = '0;
        #2;
        chk("l3_idle", busy1, 0);

        // Randomized traffic against the transaction model (pointer restarts at 0)
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            p_act[r] = 1'b0; p_we[r] = 1'b0; p_adr[r] = '0; p_dat[r] = '0;
        end
        m_ptr = 0; m_k = -1; m_gnt = 0; drop_r = -1; m_rd = '0;
        for (int c = 0; c < 500; c++) begin
            step();
            prev = -1;
            if (drop_r >= 0) begin
                p_act[drop_r] = 1'b0;
                prev = drop_r;
                drop_r = -1;
            end
            if (m_k >= 0) begin
                m_k++;
                if (m_k > int'(L0) + 1) m_k = -1;
            end
            for (int r = 0; r < 8; r++) begin
                if (!p_act[r] && r != prev && $urandom_range(0, 3) == 0) begin
                    p_act[r] = 1'b1;
                    p_we[r]  = (r % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    tmp = $urandom;
                    tmp[11:0] = {6'b0, 6'($urandom_range(0, 63))};
                    p_adr[r] = tmp;
                    p_dat[r] = $urandom;
                end
            end
            apply_rand();
            #2;
            if (m_k < 0) begin
                w = -1;
                for (int i = 0; i < 8; i++) begin
                    if (w < 0 && p_act[(m_ptr + i) % 8]) w = (m_ptr + i) % 8;
                end
                if (w >= 0) begin
                    chk("rnd_issue", {mem_en0, mem_we0, mem_adr0}, {1'b1, p_we[w], 12'(p_adr[w])});
                    if (p_we[w]) begin
                        chk("rnd_wdat", mem_wdat0, p_dat[w]);
                        m_ram[6'(p_adr[w])] = p_dat[w];
                    end else begin
                        m_rd = m_ram[6'(p_adr[w])];
                    end
                    m_gnt = w;
                    m_ptr = (w + 1) % 8;
                    m_k   = 0;
                end else begin
                    chk("rnd_idle", {busy0, mem_en0, ackv0()}, 0);
                end
            end else if (m_k == int'(L0) + 1) begin
                chk("rnd_ack", ackv0(), 8'(1) << m_gnt);
                if (!p_we[m_gnt]) begin
                    chk("rnd_rdat", (m_gnt % 2 == 1) ? inst_dat_o0 : cpu_dat_o0, m_rd);
                end
                drop_r = m_gnt;
            end else begin
                chk("rnd_wait", {busy0, mem_en0, ackv0()}, {1'b1, 1'b0, 8'h00});
            end
        end
        step();
        cpu_cyc = '0; inst_cyc = '0; cpu_we = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
